// File: rtl/vote_verify.sv
// Ballot verifier: matches a presented encrypted credential against three enrolled voter
// slots, enforces one vote per slot and keeps saturating per-candidate tallies.
module vote_verify #(
    parameter int NUM_CAND = 3,
    parameter int TALLY_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enr_valid,
    input  logic [1:0]         enr_idx,
    input  logic [127:0]       enr_cred,
    input  logic               poll_close,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [127:0]       req_cred,
    input  logic [1:0]         req_cand,
    output logic               rsp_valid,
    output logic [1:0]         rsp_code,
    output logic [1:0]         rsp_voter,
    output logic [TALLY_W-1:0] tally_0,
    output logic [TALLY_W-1:0] tally_1,
    output logic [TALLY_W-1:0] tally_2,
    output logic [TALLY_W-1:0] tally_3,
    output logic [TALLY_W-1:0] total_votes,
    output logic [2:0]         voted
);

    localparam logic [1:0] CODE_OK      = 2'd0;
    localparam logic [1:0] CODE_UNKNOWN = 2'd1;
    localparam logic [1:0] CODE_DUP     = 2'd2;
    localparam logic [1:0] CODE_REJ     = 2'd3;

    typedef enum logic [1:0] {IDLE, CMP, COMMIT, RESP} state_t;

    state_t state, state_next;

    logic [127:0]       cred [3];
    logic [2:0]         enrolled;
    logic [TALLY_W-1:0] tally [4];

    logic               accept;
    logic               enr_take;

    logic [127:0]       cred_p0;
    logic [1:0]         cand_p0;
    logic               hit;
    logic [1:0]         slot;
    logic               hit_p1;
    logic [1:0]         slot_p1;
    logic [1:0]         code_p2;
    logic [3:0]         voted_x;

    function automatic logic [TALLY_W-1:0] sat_inc(input logic [TALLY_W-1:0] v);
        return (v == '1) ? v : v + TALLY_W'(1);
    endfunction

    assign req_ready = (state == IDLE) && !enr_valid && !rst;
    assign accept    = req_valid && req_ready;
    assign enr_take  = enr_valid && (state == IDLE) && (enr_idx != 2'd3);
    assign rsp_valid = (state == RESP);

    assign tally_0 = tally[0];
    assign tally_1 = tally[1];
    assign tally_2 = tally[2];
    assign tally_3 = tally[3];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = CMP;
            CMP:     state_next = COMMIT;
            COMMIT:  state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Stage p0 -> p1: registered ballot compared against every enrolled slot; lowest index wins
    always_comb begin
        hit  = 1'b0;
        slot = 2'd3;
        for (int i = 2; i >= 0; i--) begin
            if (enrolled[i] && (cred[i] == cred_p0)) begin
                hit  = 1'b1;
                slot = 2'(i);
            end
        end
    end

    // Stage p1 -> p2: verdict, in priority order, using poll_close as seen in COMMIT
    assign voted_x = {1'b0, voted};

    always_comb begin
        code_p2 = CODE_OK;
        if (poll_close) begin
            code_p2 = CODE_REJ;
        end else if (!hit_p1) begin
            code_p2 = CODE_UNKNOWN;
        end else if (voted_x[slot_p1]) begin
            code_p2 = CODE_DUP;
        end else if (32'(cand_p0) >= 32'(NUM_CAND)) begin
            code_p2 = CODE_REJ;
        end else if (tally[cand_p0] == '1) begin
            code_p2 = CODE_REJ;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            cred_p0 <= req_cred;
            cand_p0 <= req_cand;
        end
        if (state == CMP) begin
            hit_p1  <= hit;
            slot_p1 <= slot;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) cred[i] <= '0;
            for (int i = 0; i < 4; i++) tally[i] <= '0;
            enrolled    <= '0;
            voted       <= '0;
            total_votes <= '0;
            rsp_code    <= CODE_OK;
            rsp_voter   <= 2'd3;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (enr_take && (enr_idx == 2'(i))) begin
                    cred[i]     <= enr_cred;
                    enrolled[i] <= 1'b1;
                    voted[i]    <= 1'b0;
                end
            end
            if (state == COMMIT) begin
                rsp_code  <= code_p2;
                rsp_voter <= slot_p1;
                if (code_p2 == CODE_OK) begin
                    tally[cand_p0] <= sat_inc(tally[cand_p0]);
                    total_votes    <= sat_inc(total_votes);
                    for (int i = 0; i < 3; i++) begin
                        if (slot_p1 == 2'(i)) voted[i] <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_vote_verify.sv
// Directed bench for vote_verify: enrollment, ballot outcomes, priorities, saturation and reset.
module tb_vote_verify;

    logic         clk = 1'b0;
    logic         rst;
    logic         enr_valid;
    logic [1:0]   enr_idx;
    logic [127:0] enr_cred;
    logic         poll_close;
    logic         req_valid;
    logic         req_ready;
    logic [127:0] req_cred;
    logic [1:0]   req_cand;
    logic         rsp_valid;
    logic [1:0]   rsp_code;
    logic [1:0]   rsp_voter;
    logic [7:0]   tally_0, tally_1, tally_2, tally_3;
    logic [7:0]   total_votes;
    logic [2:0]   voted;

    int n_chk  = 0;
    int n_fail = 0;

    localparam logic [127:0] CA = 128'h0123_4567_89ab_cdef_0011_2233_4455_6677;
    localparam logic [127:0] CB = 128'hfeed_beef_cafe_f00d_1234_5678_9abc_def0;
    localparam logic [127:0] CC = 128'h5a5a_a5a5_0f0f_f0f0_3c3c_c3c3_9696_6969;
    localparam logic [127:0] CD = 128'h0000_0000_0000_0001_0000_0000_0000_0001;
    localparam logic [127:0] CE = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    localparam logic [127:0] CF = 128'hdead_0000_beef_0000_face_0000_b00c_0000;

    vote_verify #(.NUM_CAND(3), .TALLY_W(8)) dut (
        .clk(clk), .rst(rst),
        .enr_valid(enr_valid), .enr_idx(enr_idx), .enr_cred(enr_cred),
        .poll_close(poll_close),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_cred(req_cred), .req_cand(req_cand),
        .rsp_valid(rsp_valid), .rsp_code(rsp_code), .rsp_voter(rsp_voter),
        .tally_0(tally_0), .tally_1(tally_1), .tally_2(tally_2), .tally_3(tally_3),
        .total_votes(total_votes), .voted(voted)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic enroll(input logic [1:0] idx, input logic [127:0] c);
        enr_valid = 1'b1;
        enr_idx   = idx;
        enr_cred  = c;
        tick();
        enr_valid = 1'b0;
    endtask

    task automatic ballot(input string tag, input logic [127:0] c, input logic [1:0] cand,
                          input logic pc_mid, input logic [1:0] exp_code,
                          input logic [1:0] exp_voter, output int waits);
        req_valid = 1'b1;
        req_cred  = c;
        req_cand  = cand;
        #1;
        waits = 0;
        while (!req_ready && waits < 20) begin
            tick();
            waits++;
        end
        if (!req_ready) begin
            chk({tag, "_accept"}, 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        tick();
        req_valid  = 1'b0;
        req_cred   = ~c;
        req_cand   = ~cand;
        poll_close = pc_mid;
        tick();
        tick();
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_code"}, 32'(rsp_code), 32'(exp_code));
        chk({tag, "_voter"}, 32'(rsp_voter), 32'(exp_voter));
        tick();
        chk({tag, "_rsp_drop"}, 32'(rsp_valid), 32'd0);
        poll_close = 1'b0;
    endtask

    initial begin
        int w;
        rst        = 1'b1;
        enr_valid  = 1'b0;
        enr_idx    = 2'd0;
        enr_cred   = '0;
        poll_close = 1'b0;
        req_valid  = 1'b1;
        req_cred   = CA;
        req_cand   = 2'd0;
        tick();
        tick();
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_code", 32'(rsp_code), 32'd0);
        chk("rst_rsp_voter", 32'(rsp_voter), 32'd3);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_total", 32'(total_votes), 32'd0);
        chk("rst_voted", 32'(voted), 32'd0);
        req_valid = 1'b0;
        rst = 1'b0;
        tick();
        chk("post_rst_ready", 32'(req_ready), 32'd1);

        enroll(2'd0, CA);
        enroll(2'd1, CB);
        enroll(2'd2, CC);

        ballot("ok_b1", CB, 2'd1, 1'b0, 2'd0, 2'd1, w);
        chk("ok_b1_tally1", 32'(tally_1), 32'd1);
        chk("ok_b1_tally0", 32'(tally_0), 32'd0);
        chk("ok_b1_total", 32'(total_votes), 32'd1);
        chk("ok_b1_voted", 32'(voted), 32'b010);

        ballot("dup_b", CB, 2'd2, 1'b0, 2'd2, 2'd1, w);
        chk("dup_tally2", 32'(tally_2), 32'd0);
        chk("dup_total", 32'(total_votes), 32'd1);

        ballot("unk_d", CD, 2'd0, 1'b0, 2'd1, 2'd3, w);
        ballot("badcand", CA, 2'd3, 1'b0, 2'd3, 2'd0, w);
        chk("badcand_voted", 32'(voted), 32'b010);
        chk("badcand_tally3", 32'(tally_3), 32'd0);

        ballot("ok_c2", CC, 2'd2, 1'b0, 2'd0, 2'd2, w);
        chk("ok_c2_tally2", 32'(tally_2), 32'd1);
        chk("ok_c2_total", 32'(total_votes), 32'd2);
        chk("ok_c2_voted", 32'(voted), 32'b110);
        tick();
        tick();
        chk("hold_code", 32'(rsp_code), 32'd0);
        chk("hold_voter", 32'(rsp_voter), 32'd2);

        enroll(2'd2, CA);
        chk("reenroll_clears", 32'(voted), 32'b010);
        ballot("lowest_idx", CA, 2'd0, 1'b0, 2'd0, 2'd0, w);
        chk("lowest_tally0", 32'(tally_0), 32'd1);
        chk("lowest_total", 32'(total_votes), 32'd3);
        chk("lowest_voted", 32'(voted), 32'b011);

        enroll(2'd3, CE);
        ballot("idx3_ignored", CE, 2'd0, 1'b0, 2'd1, 2'd3, w);

        enr_valid = 1'b1;
        enr_idx   = 2'd1;
        enr_cred  = CF;
        req_valid = 1'b1;
        req_cred  = CF;
        req_cand  = 2'd1;
        #1;
        chk("conflict_ready", 32'(req_ready), 32'd0);
        tick();
        enr_valid = 1'b0;
        ballot("conflict_b", CF, 2'd1, 1'b0, 2'd0, 2'd1, w);
        chk("conflict_waits", 32'(w), 32'd0);
        chk("conflict_tally1", 32'(tally_1), 32'd2);
        chk("conflict_total", 32'(total_votes), 32'd4);
        chk("conflict_voted", 32'(voted), 32'b011);

        enroll(2'd2, CC);
        ballot("poll_mid", CC, 2'd0, 1'b1, 2'd3, 2'd2, w);
        chk("poll_tally0", 32'(tally_0), 32'd1);
        chk("poll_total", 32'(total_votes), 32'd4);
        chk("poll_voted", 32'(voted), 32'b011);
        ballot("poll_unk", CD, 2'd0, 1'b1, 2'd3, 2'd3, w);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("rst2_total", 32'(total_votes), 32'd0);
        chk("rst2_tally1", 32'(tally_1), 32'd0);
        chk("rst2_voted", 32'(voted), 32'd0);
        ballot("unenrolled_zero", 128'd0, 2'd0, 1'b0, 2'd1, 2'd3, w);

        enroll(2'd0, CA);
        req_valid = 1'b1;
        req_cred  = CA;
        req_cand  = 2'd0;
        #1;
        tick();
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_ready", 32'(req_ready), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("midrst_ready_back", 32'(req_ready), 32'd1);
        for (int k = 0; k < 4; k++) begin
            chk("midrst_no_rsp", 32'(rsp_valid), 32'd0);
            tick();
        end
        chk("midrst_total", 32'(total_votes), 32'd0);
        chk("midrst_tally0", 32'(tally_0), 32'd0);
        chk("midrst_voted", 32'(voted), 32'd0);

        for (int k = 0; k < 255; k++) begin
            enroll(2'd0, CA);
            ballot("fill", CA, 2'd0, 1'b0, 2'd0, 2'd0, w);
        end
        chk("fill_tally0", 32'(tally_0), 32'd255);
        chk("fill_total", 32'(total_votes), 32'd255);
        enroll(2'd0, CA);
        ballot("sat_rej", CA, 2'd0, 1'b0, 2'd3, 2'd0, w);
        chk("sat_tally0", 32'(tally_0), 32'd255);
        chk("sat_total", 32'(total_votes), 32'd255);
        chk("sat_voted", 32'(voted), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
